// File: rtl/glb_bank_req_ctrl_pkg.sv
// Shared widths, bank timing constants and the request payload for the GLB bank requester.
package glb_bank_req_ctrl_pkg;

    localparam int unsigned BANK_ADDR_WIDTH  = 17;
    localparam int unsigned BANK_DATA_WIDTH  = 64;
    localparam int unsigned BANK_STRB_WIDTH  = BANK_DATA_WIDTH / 8;
    localparam int unsigned BANK_BYTE_OFFSET = $clog2(BANK_STRB_WIDTH);
    localparam int unsigned RD_LATENCY       = 3;
    localparam int unsigned RSP_FIFO_DEPTH   = 4;

    typedef struct packed {
        logic                       wr;
        logic [BANK_ADDR_WIDTH-1:0] addr;
        logic [BANK_DATA_WIDTH-1:0] data;
        logic [BANK_STRB_WIDTH-1:0] strb;
    } glb_bank_req_t;

    // Expand byte enables into the bank's per-bit write mask.
    function automatic logic [BANK_DATA_WIDTH-1:0] strb_to_bit_sel(input logic [BANK_STRB_WIDTH-1:0] strb);
        logic [BANK_DATA_WIDTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < int'(BANK_STRB_WIDTH); i++) begin
            sel[i*8 +: 8] = {8{strb[i]}};
        end
        return sel;
    endfunction

endpackage

// File: rtl/glb_bank_rsp_fifo.sv
// Response FIFO for glb_bank_req_ctrl; only compiled when GLB_BANK_RSP_FIFO_EN is defined.
`ifdef GLB_BANK_RSP_FIFO_EN
module glb_bank_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push_c, do_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        if (do_push_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`endif

// File: rtl/glb_bank_req_ctrl.sv
// Requester-side controller for one GLB bank: issues reads/writes, tracks read latency, returns data in order.
// Optional response buffering with read credit flow control: define GLB_BANK_RSP_FIFO_EN.
module glb_bank_req_ctrl
    import glb_bank_req_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [BANK_ADDR_WIDTH-1:0] req_addr,
    input  logic [BANK_DATA_WIDTH-1:0] req_data,
    input  logic [BANK_STRB_WIDTH-1:0] req_strb,
    output logic                       rd_rsp_valid,
    input  logic                       rd_rsp_ready,
    output logic [BANK_DATA_WIDTH-1:0] rd_rsp_data,
    output logic                       mem_ren,
    output logic                       mem_wen,
    output logic [BANK_ADDR_WIDTH-1:0] mem_addr,
    output logic [BANK_DATA_WIDTH-1:0] mem_data_in,
    output logic [BANK_DATA_WIDTH-1:0] mem_data_in_bit_sel,
    input  logic [BANK_DATA_WIDTH-1:0] mem_data_out,
    output logic                       idle
);

    glb_bank_req_t         req_c;
    logic                  accept_c;
    logic                  rd_accept_c;
    logic                  capture_c;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;

    assign req_c       = '{wr: req_wr, addr: req_addr, data: req_data, strb: req_strb};
    assign accept_c    = req_valid & req_ready;
    assign rd_accept_c = accept_c & ~req_c.wr;
    assign capture_c   = inflight_q[RD_LATENCY-1];
    assign inflight_d  = (inflight_q << 1) | RD_LATENCY'(rd_accept_c);

    // Bank command is presented in the accept cycle; bit_sel stays zero for reads.
    always_comb begin
        mem_ren             = 1'b0;
        mem_wen             = 1'b0;
        mem_addr            = '0;
        mem_data_in         = '0;
        mem_data_in_bit_sel = '0;
        if (accept_c) begin
            mem_wen     = req_c.wr;
            mem_ren     = ~req_c.wr;
            mem_addr    = req_c.addr;
            mem_data_in = req_c.data;
            if (req_c.wr) begin
                mem_data_in_bit_sel = strb_to_bit_sel(req_c.strb);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

`ifdef GLB_BANK_RSP_FIFO_EN
    localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] inflight_cnt_c;
    logic [CNT_W-1:0] fifo_count_c;
    logic             fifo_empty_c;
    logic             fifo_full_unused;
    logic             credit_c;

    always_comb begin
        inflight_cnt_c = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight_cnt_c = inflight_cnt_c + CNT_W'(inflight_q[i]);
        end
    end

    // A read needs a guaranteed FIFO slot; a pop in the same cycle does not free one.
    assign credit_c     = (SUM_W'(inflight_cnt_c) + SUM_W'(fifo_count_c)) < SUM_W'(RSP_FIFO_DEPTH);
    assign req_ready    = req_c.wr | credit_c;
    assign rd_rsp_valid = ~fifo_empty_c;
    assign idle         = (inflight_q == '0) & fifo_empty_c & ~rd_rsp_valid;

    glb_bank_rsp_fifo #(
        .DATA_WIDTH (BANK_DATA_WIDTH),
        .DEPTH      (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (capture_c),
        .push_data (mem_data_out),
        .pop       (rd_rsp_valid & rd_rsp_ready),
        .pop_data  (rd_rsp_data),
        .full      (fifo_full_unused),
        .empty     (fifo_empty_c),
        .count     (fifo_count_c)
    );
`else
    logic                       rd_rsp_valid_q, rd_rsp_valid_d;
    logic [BANK_DATA_WIDTH-1:0] rd_rsp_data_q, rd_rsp_data_d;
    logic                       rsp_ready_unused;

    assign rsp_ready_unused = rd_rsp_ready;
    assign req_ready        = 1'b1;

    // Single-cycle response pulse; data holds until the next capture.
    always_comb begin
        rd_rsp_valid_d = capture_c;
        rd_rsp_data_d  = rd_rsp_data_q;
        if (capture_c) begin
            rd_rsp_data_d = mem_data_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_data_q  <= '0;
        end else begin
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
        end
    end

    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign idle         = (inflight_q == '0) & ~rd_rsp_valid_q;
`endif

endmodule

// File: tb/tb_glb_bank_req_ctrl.sv
// Bench for glb_bank_req_ctrl paired with a behavioural 3-cycle bank memory and a response scoreboard.
module tb_glb_bank_req_ctrl;
    import glb_bank_req_ctrl_pkg::*;

    localparam int unsigned WORDS = 1 << (BANK_ADDR_WIDTH - BANK_BYTE_OFFSET);

    logic                       clk;
    logic                       reset_n;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr;
    logic [BANK_ADDR_WIDTH-1:0] req_addr;
    logic [BANK_DATA_WIDTH-1:0] req_data;
    logic [BANK_STRB_WIDTH-1:0] req_strb;
    logic                       rd_rsp_valid;
    logic                       rd_rsp_ready;
    logic [BANK_DATA_WIDTH-1:0] rd_rsp_data;
    logic                       mem_ren;
    logic                       mem_wen;
    logic [BANK_ADDR_WIDTH-1:0] mem_addr;
    logic [BANK_DATA_WIDTH-1:0] mem_data_in;
    logic [BANK_DATA_WIDTH-1:0] mem_data_in_bit_sel;
    logic [BANK_DATA_WIDTH-1:0] mem_data_out;
    logic                       idle;

    typedef struct {
        logic [BANK_DATA_WIDTH-1:0] data;
        int                         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   cyc      = 0;

    glb_bank_req_ctrl dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_wr              (req_wr),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_strb            (req_strb),
        .rd_rsp_valid        (rd_rsp_valid),
        .rd_rsp_ready        (rd_rsp_ready),
        .rd_rsp_data         (rd_rsp_data),
        .mem_ren             (mem_ren),
        .mem_wen             (mem_wen),
        .mem_addr            (mem_addr),
        .mem_data_in         (mem_data_in),
        .mem_data_in_bit_sel (mem_data_in_bit_sel),
        .mem_data_out        (mem_data_out),
        .idle                (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bank memory: bit-masked write, read data valid RD_LATENCY cycles after ren.
    logic [BANK_DATA_WIDTH-1:0] bank [WORDS];
    logic [BANK_DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];

    always @(posedge clk) begin
        if (mem_wen) begin
            bank[mem_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET]] <=
                (bank[mem_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET]] & ~mem_data_in_bit_sel) |
                (mem_data_in & mem_data_in_bit_sel);
        end
        rd_pipe[0] <= bank[mem_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET]];
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_data_out = rd_pipe[RD_LATENCY-1];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted response is popped and compared in order.
    always @(negedge clk) begin
        if (reset_n && rd_rsp_valid && rd_rsp_ready) begin
            n_rsp++;
            chk1("rsp_expected", 1'(sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk64("rsp_data", rd_rsp_data, e.data);
`ifdef GLB_BANK_RSP_FIFO_EN
                chk1("rsp_not_early", 1'(cyc >= e.cyc), 1'b1);
`else
                chk64("rsp_cycle", 64'(cyc), 64'(e.cyc));
`endif
            end
        end
    end

    // Present one request at a negedge, wait for acceptance, check the bank command.
    task automatic issue(input logic wr, input logic [BANK_ADDR_WIDTH-1:0] addr,
                         input logic [BANK_DATA_WIDTH-1:0] data, input logic [BANK_STRB_WIDTH-1:0] strb,
                         input logic [BANK_DATA_WIDTH-1:0] exp_rsp, input bit track);
        int waited;
        logic [BANK_DATA_WIDTH-1:0] sel;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        req_strb  = strb;
        #1;
        waited = 0;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk1("req_ready", req_ready, 1'b1);
        sel = '0;
        if (wr) begin
            for (int i = 0; i < int'(BANK_STRB_WIDTH); i++) sel[i*8 +: 8] = {8{strb[i]}};
        end
        chk1("mem_wen", mem_wen, wr);
        chk1("mem_ren", mem_ren, ~wr);
        chk64("mem_addr", 64'(mem_addr), 64'(addr));
        chk64("mem_bit_sel", mem_data_in_bit_sel, sel);
        if (wr) chk64("mem_data_in", mem_data_in, data);
        if (!wr && track) sb_q.push_back('{data: exp_rsp, cyc: cyc + 4});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 64) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk64(tag, 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        chk1("idle_after_drain", idle, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int rsp_before;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_strb     = '0;
        rd_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_rsp_valid", rd_rsp_valid, 1'b0);
        chk64("rst_rsp_data", rd_rsp_data, 64'd0);
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_mem_ren", mem_ren, 1'b0);
        chk1("rst_mem_wen", mem_wen, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("ready_after_rst", req_ready, 1'b1);

        // Full write then read back with exact latency.
        issue(1'b1, 17'h0010, 64'h1122334455667788, 8'hFF, '0, 1'b0);
        issue(1'b0, 17'h0010, '0, '0, 64'h1122334455667788, 1'b1);
        chk1("idle_busy", idle, 1'b0);
        wait_drain("drain_full_write");

        // Partial write, byte-offset address and a no-op write.
        issue(1'b1, 17'h0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, '0, 1'b0);
        issue(1'b0, 17'h0010, '0, '0, 64'h11223344AAAAAAAA, 1'b1);
        issue(1'b0, 17'h0013, '0, '0, 64'h11223344AAAAAAAA, 1'b1);
        issue(1'b1, 17'h0010, 64'h0, 8'h00, '0, 1'b0);
        issue(1'b0, 17'h0010, '0, '0, 64'h11223344AAAAAAAA, 1'b1);
        wait_drain("drain_partial");

        // Eight back-to-back reads after filling words 0x00..0x38.
        for (int k = 0; k < 8; k++)
            issue(1'b1, BANK_ADDR_WIDTH'(k * 8), 64'hC0DE_0000_0000_0000 | 64'(k), 8'hFF, '0, 1'b0);
        for (int k = 0; k < 8; k++)
            issue(1'b0, BANK_ADDR_WIDTH'(k * 8), '0, '0, 64'hC0DE_0000_0000_0000 | 64'(k), 1'b1);
        wait_drain("drain_b2b");

`ifdef GLB_BANK_RSP_FIFO_EN
        // Credit exhaustion with a stalled consumer, then drain in order.
        rd_rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_wr    = 1'b0;
            req_addr  = BANK_ADDR_WIDTH'(acc * 8);
            req_strb  = '0;
            #1;
            if (req_ready && acc < 6) begin
                sb_q.push_back('{data: 64'hC0DE_0000_0000_0000 | 64'(acc), cyc: cyc + 4});
                acc++;
            end
            @(negedge clk);
        end
        chk64("fifo_accepted", 64'(acc), 64'd4);
        chk1("fifo_ready_low", req_ready, 1'b0);
        rd_rsp_ready = 1'b1;
        issue(1'b0, 17'h0020, '0, '0, 64'hC0DE_0000_0000_0004, 1'b1);
        issue(1'b0, 17'h0028, '0, '0, 64'hC0DE_0000_0000_0005, 1'b1);
        wait_drain("drain_fifo");
`endif

        // Reset two cycles after a read accept drops the read.
        rsp_before = n_rsp;
        issue(1'b0, 17'h0010, '0, '0, '0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk1("midrst_rsp_valid", rd_rsp_valid, 1'b0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk64("midrst_no_rsp", 64'(n_rsp), 64'(rsp_before));
        chk1("midrst_idle", idle, 1'b1);
        chk64("midrst_rsp_data", rd_rsp_data, 64'd0);

        // Reads still work after the mid-operation reset.
        issue(1'b0, 17'h0038, '0, '0, 64'hC0DE_0000_0000_0007, 1'b1);
        wait_drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
